// File: rtl/comb_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comb_sweep_ctrl
// Brief    : Clocked sweep sequencer that drives every input vector onto the
//            shared A/B/C/D bus, compares all variant outputs and records
//            mismatch statistics plus the truth table of variant 0.
// Revision : 1.0 - initial release
// ============================================================================
module comb_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int N_IMPL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        abcd,
    input  logic [N_IMPL-1:0]      y_in,
    output logic                   busy,
    output logic                   done,
    output logic                   result_ok,
    output logic [N_IN:0]          mismatch_cnt,
    output logic                   first_fail_valid,
    output logic [N_IN-1:0]        first_fail_vec,
    output logic [(1<<N_IN)-1:0]   truth_table
);

    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_ZERO = {(N_IN+1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q;
    logic            vec_mismatch;
    logic [N_IN:0]   mismatch_cnt_d;

    // Variants agree only when every output bit carries the same value.
    assign vec_mismatch   = (y_in != {N_IMPL{1'b0}}) && (y_in != {N_IMPL{1'b1}});
    assign mismatch_cnt_d = vec_mismatch ? (mismatch_cnt + CNT_ONE) : mismatch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            abcd             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            result_ok        <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            truth_table      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q          <= ST_DRIVE;
                        abcd             <= '0;
                        busy             <= 1'b1;
                        result_ok        <= 1'b0;
                        mismatch_cnt     <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        truth_table      <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Abort discards the sample taken on this edge.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        truth_table[abcd] <= y_in[0];
                        mismatch_cnt      <= mismatch_cnt_d;
                        if (vec_mismatch && !first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= abcd;
                        end
                        if (abcd != LAST_VEC) begin
                            abcd    <= abcd + VEC_ONE;
                            state_q <= ST_DRIVE;
                        end else begin
                            state_q   <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            result_ok <= (mismatch_cnt_d == CNT_ZERO);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
